// File: rtl/mux8_sched_pkg.sv
// Shared constants, FSM state type and helpers for the 8-source mux scheduler.
package mux8_sched_pkg;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    // Scheduler FSM states: no owner, owner active, one-cycle dead gap.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    // One-hot decode of a source index into a grant vector.
    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request bit after ptr, wrapping back to ptr.
module rr_pick
    import mux8_sched_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] w,
    output logic             found
);

    logic [2*N-1:0]   req_dbl;
    logic [SEL_W:0]   rot_off;
    logic [N-1:0]     req_rot;
    logic [SEL_W-1:0] rot_pos;

    // Rotate so the bit after ptr lands at position 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        rot_off = {1'b0, ptr} + {{SEL_W{1'b0}}, 1'b1};
        req_rot = req_dbl[rot_off +: N];
        rot_pos = '0;
        found   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_pos = SEL_W'(i);
                found   = 1'b1;
            end
        end
        // Un-rotate: modulo-N add happens naturally in SEL_W bits.
        w = ptr + {{(SEL_W-1){1'b0}}, 1'b1} + rot_pos;
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select and one-hot grant of a shared 8:1 mux.
// Each grant lasts at most MAX_HOLD cycles (MAX_HOLD must be >= 1) and is
// followed by exactly one dead cycle with no owner.
//
// Handshake: req[i] is a level request; source i owns the mux output whenever
// gnt[i] is high. gnt follows req by one clock, and the owner keeps gnt for
// one more cycle after dropping req. There is no backpressure on gnt.
module mux8_rr_sched
    import mux8_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    sched_state_e      state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [N-1:0]      gnt_q;
    logic              valid_q;
    logic [HOLD_W-1:0] hold_q;
    logic [SEL_W-1:0]  ptr_q;

    logic [SEL_W-1:0]  win;
    logic              win_found;
    logic              grant_end;

    // Search always starts just after the last finished owner.
    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .w     (win),
        .found (win_found)
    );

    // Current grant finishes when its owner lets go, enable drops or the hold limit is hit.
    always_comb begin
        grant_end = !req[sel_q] || !en || (hold_q == HOLD_W'(MAX_HOLD));
    end

    // Scheduler FSM with registered select, grant, valid, hold counter and pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= SEL_W'(N - 1);
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    // sel is left alone so the mux output stays stable between owners.
                    if (en && win_found) begin
                        state_q <= GRANT;
                        sel_q   <= win;
                        gnt_q   <= onehot(win);
                        valid_q <= 1'b1;
                        hold_q  <= HOLD_W'(1);
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        hold_q  <= '0;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        state_q <= GAP;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        hold_q  <= '0;
                        ptr_q   <= sel_q;
                    end else begin
                        hold_q  <= hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign sel   = sel_q;
    assign gnt   = gnt_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_mux8_rr_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic [7:0] gnt_a;
    logic [7:0] gnt_b;
    logic       valid_a;
    logic       valid_b;

    int checks = 0;
    int errors = 0;

    mux8_rr_sched #(.MAX_HOLD(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req_a),
        .sel   (sel_a),
        .gnt   (gnt_a),
        .valid (valid_a)
    );

    mux8_rr_sched #(.MAX_HOLD(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req_b),
        .sel   (sel_b),
        .gnt   (gnt_b),
        .valid (valid_b)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] exp_sel, input logic [7:0] exp_gnt);
        chk({tag, "_a_sel"}, {5'd0, sel_a}, {5'd0, exp_sel});
        chk({tag, "_a_gnt"}, gnt_a, exp_gnt);
        chk({tag, "_a_valid"}, {7'd0, valid_a}, {7'd0, (exp_gnt != 8'h00)});
    endtask

    task automatic chk_b(input string tag, input logic [2:0] exp_sel, input logic [7:0] exp_gnt);
        chk({tag, "_b_sel"}, {5'd0, sel_b}, {5'd0, exp_sel});
        chk({tag, "_b_gnt"}, gnt_b, exp_gnt);
        chk({tag, "_b_valid"}, {7'd0, valid_b}, {7'd0, (exp_gnt != 8'h00)});
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req_a = 8'h00;
        req_b = 8'h00;
        repeat (3) tick();
        chk_a("reset", 3'd0, 8'h00);
        chk_b("reset", 3'd0, 8'h00);

        // Reset release and first pick: sources 2 and 5 alternate, 4 on / 1 off.
        rst_n = 1'b1;
        req_a = 8'h24;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_a("first_pick_src2", 3'd2, 8'h04);
        end
        tick();
        chk_a("gap_after_src2", 3'd2, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_a("grant_src5", 3'd5, 8'h20);
        end
        tick();
        chk_a("gap_after_src5", 3'd5, 8'h00);
        tick();
        chk_a("back_to_src2", 3'd2, 8'h04);
        req_a = 8'h00;
        tick();
        chk_a("drop_gap", 3'd2, 8'h00);
        tick();
        chk_a("drop_idle", 3'd2, 8'h00);

        // Sole requester: re-granted after each timeout gap.
        req_a = 8'h80;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_a("sole_on", 3'd7, 8'h80);
            end
            tick();
            chk_a("sole_gap", 3'd7, 8'h00);
        end
        req_a = 8'h00;
        tick();
        chk_a("sole_idle", 3'd7, 8'h00);

        // Early release: source 3 drops on its second grant cycle, source 4 follows.
        req_a = 8'h18;
        tick();
        chk_a("early_src3_c1", 3'd3, 8'h08);
        tick();
        chk_a("early_src3_c2", 3'd3, 8'h08);
        req_a = 8'h10;
        tick();
        chk_a("early_gap", 3'd3, 8'h00);
        tick();
        chk_a("early_src4", 3'd4, 8'h10);
        req_a = 8'h00;
        tick();
        chk_a("early_tail_gap", 3'd4, 8'h00);
        tick();
        chk_a("early_tail_idle", 3'd4, 8'h00);

        // Rotation with MAX_HOLD=1: 0..7 then 0 again, one gap between each.
        req_b = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_b("rot_grant", 3'(i % 8), 8'h01 << (i % 8));
            tick();
            chk_b("rot_gap", 3'(i % 8), 8'h00);
        end
        req_b = 8'h00;
        tick();
        chk_b("rot_idle", 3'd0, 8'h00);

        // Enable gating.
        en    = 1'b0;
        req_a = 8'h01;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_a("en_low_block", 3'd4, 8'h00);
        end
        en = 1'b1;
        tick();
        chk_a("en_high_grant", 3'd0, 8'h01);
        tick();
        chk_a("en_high_hold", 3'd0, 8'h01);
        en = 1'b0;
        tick();
        chk_a("en_drop_clear", 3'd0, 8'h00);
        en = 1'b1;
        tick();
        chk_a("en_regrant", 3'd0, 8'h01);

        // Mid-grant asynchronous reset.
        req_a = 8'h20;
        tick();
        chk_a("pre_rst_gap", 3'd0, 8'h00);
        tick();
        chk_a("pre_rst_src5", 3'd5, 8'h20);
        tick();
        chk_a("pre_rst_src5_c2", 3'd5, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst", 3'd0, 8'h00);
        chk_b("async_rst", 3'd0, 8'h00);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_a("post_rst_full_hold", 3'd5, 8'h20);
        end
        tick();
        chk_a("post_rst_gap", 3'd5, 8'h00);
        req_a = 8'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
Round-robin scheduler that shares one 8:1 select path between 8 requesters. It arbitrates among level requests and drives the 3-bit mux select plus a one-hot grant. Each grant is bounded by a hold limit, and grants are separated by a mandatory 1-cycle dead gap. It sits directly in front of the 8:1 mux: `sel` feeds the mux select, and `gnt` tells each source when its data is on the mux output.

Parameters:
- N, 8, number of requesters (fixed to 8 for this mux; a parameter only for the package constant).
- SEL_W, 3, select width, equal to clog2(N).
- MAX_HOLD, 16, maximum consecutive cycles a single grant may last; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; low blocks new grants and terminates the current one.
- req  in  N  level request per source; bit i = source i.
- sel  out  SEL_W  mux select; index of the current/last owner.
- gnt  out  N  one-hot grant; all-zero when no owner.
- valid  out  1  high while a grant is active (equal to |gnt).

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, sel=0, gnt=0, valid=0, hold_cnt=0, ptr=N-1. Setting ptr=N-1 makes the first search start at index 0.
- All outputs are registered. There is no combinational path from req to any output.
- Winner search, pick(ptr, req): returns the first set bit of req scanning ptr+1, ptr+2, …, wrapping modulo N, ending at ptr itself.
- State IDLE:
  - gnt=0, valid=0, sel holds its value.
  - If en && |req: go to GRANT next cycle with sel=w, gnt=onehot(w), valid=1, hold_cnt=1, where w=pick(ptr, req).
  - Latency from req to gnt is 1 clock.
- State GRANT (owner=sel):
  - End condition: req[owner]==0, or en==0, or hold_cnt==MAX_HOLD.
  - If the end condition holds, go to GAP next cycle: gnt=0, valid=0, ptr=owner.
  - Otherwise hold_cnt increments and gnt/sel are unchanged.
  - The owner therefore sees gnt for exactly 1 more cycle after dropping req.
  - gnt is asserted for at most MAX_HOLD consecutive cycles.
- State GAP (exactly 1 cycle):
  - gnt=0, valid=0, sel unchanged, so the mux output is stable while no one owns it.
  - If en && |req: w=pick(ptr, req), then GRANT as from IDLE. Otherwise go to IDLE.
  - Minimum spacing between two grants is exactly 1 idle cycle.
- Fairness:
  - ptr updates only on grant end, to the finished owner.
  - After a timeout, a sole remaining requester is re-granted after the gap, because the search wraps back to itself.
  - Any other requester waits at most (N-1)·(MAX_HOLD+1) cycles.
- Requests raised or dropped by non-owners during GRANT have no effect until the next pick.
- Reset asserted mid-grant: outputs return to reset values immediately (asynchronous), ptr=N-1, and no partial hold is remembered.
- hold_cnt width is clog2(MAX_HOLD+1). It never wraps, because the transition happens at MAX_HOLD.
- When MAX_HOLD=1, each grant lasts exactly 1 cycle and is followed by a gap.

Decomposition:
- Shared package mux8_sched_pkg:
  - constants N=8, SEL_W=3;
  - state typedef {IDLE, GRANT, GAP};
  - function onehot(idx).
- One combinational sub-module rr_pick (inputs req[N], ptr[SEL_W]; outputs w[SEL_W], found). It implements the rotate, priority-encode and un-rotate search.
- The top-level holds the FSM, hold counter, pointer and output registers.

Test Plan:
- Reset/first pick (MAX_HOLD=4): release rst_n, then req=8'h24 held.
  - Required: 1 cycle later sel=2, gnt=8'h04, valid=1 for 4 cycles; then 1 gap cycle with gnt=0 and sel=2; then sel=5, gnt=8'h20 for 4 cycles; then back to sel=2.
- Sole requester timeout: req=8'h80 held, MAX_HOLD=4.
  - Required: gnt=8'h80 repeats as 4 on, 1 off, indefinitely; sel=7 throughout.
- Early release: grant to source 3 active, drop req[3] on grant cycle 2.
  - Required: gnt=8'h08 deasserts on the next cycle; 1 gap cycle; then source 4 is granted if req[4]=1.
- Rotation order: req=8'hFF with MAX_HOLD=1.
  - Required: sel sequence 0,1,2,…,7,0, with one gnt=0 cycle between each.
- Enable and mid-grant reset:
  - en=0 with req=8'h01: gnt stays 0.
  - Dropping en mid-grant: gnt clears next cycle.
  - Asserting rst_n=0 mid-grant: gnt=0, sel=0, valid=0 asynchronously, with no wait for a clock edge.
